hvps_ramp_ctrl: RTL and testbench

//  Parametrised MCP HVPS ramp controller driving an apes_dac write port (dac_set/dac_pulse).

---
 rtl/hvps_ramp_ctrl_if.sv | 12 +
 rtl/hvps_ramp_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_hvps_ramp_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hvps_ramp_ctrl_if.sv
// DAC write port between the HVPS ramp controller and the apes_dac serialiser.
// The controller drives code and strobe. The serialiser reports busy.
interface hvps_ramp_ctrl_if #(
  parameter int DW = 12
) ();
  logic [DW-1:0] dac_set;
  logic          dac_pulse;
  logic          dac_busy;

  modport master (output dac_set, output dac_pulse, input dac_busy);
  modport slave  (input dac_set, input dac_pulse, output dac_busy);
endinterface

// File: rtl/hvps_ramp_ctrl.sv
// MCP HVPS ramp controller.
// Steps the DAC code towards a programmable target, one step per dwell period,
// holds there and follows retargets. A safe request ramps the code down
// gracefully; an emergency off drops it to 0 at once. A stuck DAC serialiser
// latches a fault. DAC writes go through a one-deep mailbox: a newer write
// replaces an older one that has not been issued yet, and each issue produces
// exactly one strobe.
module hvps_ramp_ctrl #(
  parameter int DW          = 12,
  parameter int STEP        = 228,
  parameter int TICK_DIV    = 256,
  parameter int DWELL_TICKS = 86784,
  parameter int SETTLE_TKS  = 194,
  parameter int BUSY_TO     = 4096
) (
  input  logic                   clk50,
  input  logic                   rst_n,
  input  logic                   hven_cmd,
  input  logic                   safe_cmd,
  input  logic                   reset_cmd,
  input  logic [DW-1:0]          target,
  hvps_ramp_ctrl_if.master       dac,
  output logic                   hven,
  output logic [2:0]             ramp_state,
  output logic                   at_target,
  output logic                   fault
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_UP     = 3'd2,
    S_HOLD   = 3'd3,
    S_DOWN   = 3'd4,
    S_SAFE   = 3'd5
  } state_t;

  localparam int TW        = $clog2(TICK_DIV);
  localparam int DWELL_MAX = (DWELL_TICKS > SETTLE_TKS) ? DWELL_TICKS : SETTLE_TKS;
  localparam int CW        = $clog2(DWELL_MAX + 1);
  localparam int BW        = $clog2(BUSY_TO + 1);
  localparam logic [DW-1:0] STEP_D = DW'(STEP);

  state_t          state, state_n;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [CW-1:0]   dwell_cnt, dwell_n;
  logic            dwell_done;
  logic [BW-1:0]   busy_cnt;
  logic            busy_trip;
  logic [DW-1:0]   level, level_n;
  logic [DW-1:0]   floor_lvl, floor_n;
  logic [DW-1:0]   tgt;
  logic            hven_n, fault_n;
  logic            wr_req;
  logic            pend;
  logic [DW-1:0]   pend_val;
  logic [DW:0]     up_sum;
  logic [DW-1:0]   up_lvl, dn_lvl;

  assign tick       = (tick_cnt == TW'(TICK_DIV - 1));
  assign dwell_done = tick && ((state == S_SETTLE) ? (dwell_cnt == CW'(SETTLE_TKS - 1))
                                                   : (dwell_cnt == CW'(DWELL_TICKS - 1)));
  assign busy_trip  = pend && dac.dac_busy && (busy_cnt == BW'(BUSY_TO - 1));

  // Saturating step arithmetic: one extra bit keeps level+STEP from wrapping.
  assign up_sum = {1'b0, level} + {1'b0, STEP_D};
  assign up_lvl = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[DW-1:0];
  assign dn_lvl = ({1'b0, level} >= ({1'b0, floor_lvl} + {1'b0, STEP_D})) ? (level - STEP_D)
                                                                          : floor_lvl;

  assign ramp_state = state;
  assign at_target  = (state == S_HOLD) && (level == tgt);

  // Free-running tick prescaler, realigned by an emergency off.
  always_ff @(posedge clk50 or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would make results depend on block order.
    if (!rst_n)              tick_cnt <= '0;
    else if (reset_cmd || tick) tick_cnt <= '0;
    else                     tick_cnt <= tick_cnt + TW'(1);
  end

  // Next-state, level and write-request decode: reset_cmd > fault > safe_cmd > hven_cmd.
  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves one unassigned and a latch is never inferred.
    state_n = state;
    level_n = level;
    floor_n = floor_lvl;
    hven_n  = hven;
    fault_n = fault;
    wr_req  = 1'b0;

    if (reset_cmd) begin
      fault_n = 1'b0;
      hven_n  = 1'b0;
      level_n = '0;
      wr_req  = (level != '0);
      // SAFE is left only when the safe request has been withdrawn.
      state_n = (state == S_SAFE && safe_cmd) ? S_SAFE : S_IDLE;
    end else if (fault || busy_trip) begin
      fault_n = 1'b1;
      hven_n  = 1'b0;
      level_n = '0;
      wr_req  = (level != '0);
      state_n = S_SAFE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (safe_cmd) begin
            state_n = S_SAFE;
          end else if (hven_cmd) begin
            state_n = S_SETTLE;
            hven_n  = 1'b1;
          end
        end
        S_SETTLE: begin
          if (safe_cmd || !hven_cmd) begin
            state_n = S_DOWN;
            floor_n = '0;
          end else if (dwell_done) begin
            state_n = S_UP;
          end
        end
        S_UP: begin
          if (safe_cmd || !hven_cmd) begin
            state_n = S_DOWN;
            floor_n = '0;
          end else if (level == tgt) begin
            state_n = S_HOLD;
          end else if (tgt < level) begin
            state_n = S_DOWN;
            floor_n = tgt;
          end else if (dwell_done) begin
            level_n = up_lvl;
            wr_req  = 1'b1;
          end
        end
        S_HOLD: begin
          if (safe_cmd || !hven_cmd) begin
            state_n = S_DOWN;
            floor_n = '0;
          end else if (tgt > level) begin
            state_n = S_UP;
          end else if (tgt < level) begin
            state_n = S_DOWN;
            floor_n = tgt;
          end
        end
        S_DOWN: begin
          if (level == floor_lvl) begin
            if (floor_lvl != '0) begin
              state_n = S_HOLD;
            end else begin
              hven_n  = 1'b0;
              state_n = safe_cmd ? S_SAFE : S_IDLE;
            end
          end else begin
            // A late safe/off request lowers the floor; the step in flight still uses the old one.
            if (safe_cmd || !hven_cmd) floor_n = '0;
            if (dwell_done) begin
              level_n = dn_lvl;
              wr_req  = 1'b1;
            end
          end
        end
        S_SAFE: begin
          hven_n = 1'b0;
        end
        default: state_n = S_IDLE;
      endcase
    end

    // The dwell counter restarts on every state change.
    if (reset_cmd || state_n != state) dwell_n = '0;
    else if (tick)                     dwell_n = dwell_done ? '0 : dwell_cnt + CW'(1);
    else                               dwell_n = dwell_cnt;
  end

  // Control state registers, with the target sampled once per tick.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      level     <= '0;
      floor_lvl <= '0;
      tgt       <= '0;
      hven      <= 1'b0;
      fault     <= 1'b0;
      dwell_cnt <= '0;
    end else begin
      state     <= state_n;
      level     <= level_n;
      floor_lvl <= floor_n;
      hven      <= hven_n;
      fault     <= fault_n;
      dwell_cnt <= dwell_n;
      if (tick) tgt <= target;
    end
  end

  // One-deep write mailbox: issue when the DAC is free; a newer request overwrites an older one.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      pend          <= 1'b0;
      pend_val      <= '0;
      dac.dac_set   <= '0;
      dac.dac_pulse <= 1'b0;
      busy_cnt      <= '0;
    end else begin
      dac.dac_pulse <= 1'b0;
      if (pend && !dac.dac_busy) begin
        dac.dac_set   <= pend_val;
        dac.dac_pulse <= 1'b1;
        pend          <= 1'b0;
      end
      if (wr_req) begin
        pend     <= 1'b1;
        pend_val <= level_n;
      end
      if (reset_cmd || !(pend && dac.dac_busy)) busy_cnt <= '0;
      else if (busy_cnt != BW'(BUSY_TO - 1))    busy_cnt <= busy_cnt + BW'(1);
    end
  end

endmodule

// File: tb/tb_hvps_ramp_ctrl.sv
// Bench for hvps_ramp_ctrl with short timing parameters.
// Expected DAC codes come from an arithmetic ramp model kept in a queue.
// One negedge process pops and compares every strobe and checks the output invariants.
module tb_hvps_ramp_ctrl;
  localparam int DW       = 12;
  localparam int STEP     = 228;
  localparam int TICK_DIV = 4;
  localparam int DWELL    = 2;
  localparam int SETTLE   = 1;
  localparam int BUSY_TO  = 16;

  typedef int iq_t[$];

  logic          clk50     = 1'b0;
  logic          rst_n     = 1'b0;
  logic          hven_cmd  = 1'b0;
  logic          safe_cmd  = 1'b0;
  logic          reset_cmd = 1'b0;
  logic [DW-1:0] target    = '0;
  logic          hven, at_target, fault;
  logic [2:0]    ramp_state;

  hvps_ramp_ctrl_if #(.DW(DW)) dac ();

  hvps_ramp_ctrl #(
    .DW(DW), .STEP(STEP), .TICK_DIV(TICK_DIV), .DWELL_TICKS(DWELL),
    .SETTLE_TKS(SETTLE), .BUSY_TO(BUSY_TO)
  ) dut (
    .clk50      (clk50),
    .rst_n      (rst_n),
    .hven_cmd   (hven_cmd),
    .safe_cmd   (safe_cmd),
    .reset_cmd  (reset_cmd),
    .target     (target),
    .dac        (dac.master),
    .hven       (hven),
    .ramp_state (ramp_state),
    .at_target  (at_target),
    .fault      (fault)
  );

  always #5 clk50 = ~clk50;

  int n_checks = 0;
  int n_err    = 0;
  int n_pulse  = 0;
  int exp_q[$];

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ramp model: codes written going from 'from' to 'to' in saturating STEP increments.
  function automatic iq_t ramp(int from, int to);
    iq_t q;
    int  cur = from;
    while (cur < to) begin
      cur = (cur + STEP > to) ? to : cur + STEP;
      q.push_back(cur);
    end
    while (cur > to) begin
      cur = (cur - STEP < to) ? to : cur - STEP;
      q.push_back(cur);
    end
    return q;
  endfunction

  task automatic expect_ramp(int from, int to);
    iq_t q = ramp(from, to);
    foreach (q[i]) exp_q.push_back(q[i]);
  endtask

  task automatic wait_state(string name, int st, bit need_empty, int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk50);
      if (ramp_state == 3'(st) && (!need_empty || exp_q.size() == 0)) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, int'(ok), 1);
  endtask

  // Scoreboard and invariants, sampled on the falling edge.
  always @(negedge clk50) begin
    if (rst_n) begin
      if (dac.dac_pulse) begin
        n_pulse++;
        if (exp_q.size() == 0) check("unexpected_pulse", int'(dac.dac_set), -1);
        else                   check("pulse_code", int'(dac.dac_set), exp_q.pop_front());
      end
      if (fault) check("fault_implies_safe", int'(ramp_state), 5);
      if (ramp_state == 3'd0 || ramp_state == 3'd5) check("hven_off_idle_safe", int'(hven), 0);
    end
  end

  initial begin
    iq_t pin;
    int  p0;
    bit  ok;
    dac.dac_busy = 1'b0;

    // Pin the model against hand-computed ramps.
    pin = ramp(0, 700);
    check("pin_up_len", pin.size(), 4);
    check("pin_up_0", pin[0], 228);
    check("pin_up_3", pin[3], 700);
    pin = ramp(700, 0);
    check("pin_safe_2", pin[2], 16);
    check("pin_safe_3", pin[3], 0);
    pin = ramp(0, 4095);
    check("pin_max_len", pin.size(), 18);
    check("pin_max_16", pin[16], 3876);
    check("pin_max_17", pin[17], 4095);

    // Reset state.
    repeat (3) @(negedge clk50);
    rst_n = 1'b1;
    @(negedge clk50);
    check("rst_state", int'(ramp_state), 0);
    check("rst_hven", int'(hven), 0);
    check("rst_dac_set", int'(dac.dac_set), 0);
    check("rst_pulse", int'(dac.dac_pulse), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_at_target", int'(at_target), 0);

    // 1: ramp up to 700.
    expect_ramp(0, 700);
    target = 12'd700; hven_cmd = 1'b1;
    wait_state("t1_hold", 3, 1'b1, 200);
    check("t1_at_target", int'(at_target), 1);
    check("t1_hven", int'(hven), 1);
    check("t1_dac_set", int'(dac.dac_set), 700);

    // 2: retarget down to 300, then up to 800.
    expect_ramp(700, 300);
    target = 12'd300;
    wait_state("t2_hold_300", 3, 1'b1, 200);
    check("t2_dac_set_300", int'(dac.dac_set), 300);
    expect_ramp(300, 800);
    target = 12'd800;
    wait_state("t2_hold_800", 3, 1'b1, 200);
    check("t2_at_target_800", int'(at_target), 1);

    // 3: back to 700, then a graceful safe ramp to 0 and the SAFE exit rule.
    expect_ramp(800, 700);
    target = 12'd700;
    wait_state("t3_hold_700", 3, 1'b1, 200);
    expect_ramp(700, 0);
    safe_cmd = 1'b1;
    wait_state("t3_safe", 5, 1'b1, 300);
    check("t3_hven", int'(hven), 0);
    check("t3_dac_set", int'(dac.dac_set), 0);
    hven_cmd = 1'b0; safe_cmd = 1'b0;
    repeat (4) @(negedge clk50);
    check("t3_stay_safe_no_reset", int'(ramp_state), 5);
    safe_cmd = 1'b1; reset_cmd = 1'b1;
    repeat (3) @(negedge clk50);
    check("t3_stay_safe_with_safe", int'(ramp_state), 5);
    safe_cmd = 1'b0;
    @(negedge clk50);
    check("t3_exit_idle", int'(ramp_state), 0);
    reset_cmd = 1'b0;

    // 4: emergency off mid-ramp at level 456.
    expect_ramp(0, 456);
    target = 12'd700; hven_cmd = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk50);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    check("t4_reached_456", int'(ok), 1);
    exp_q.push_back(0);
    reset_cmd = 1'b1; hven_cmd = 1'b0;
    @(negedge clk50);
    check("t4_idle", int'(ramp_state), 0);
    check("t4_hven", int'(hven), 0);
    @(negedge clk50);
    check("t4_pulse", int'(dac.dac_pulse), 1);
    check("t4_dac_set", int'(dac.dac_set), 0);
    reset_cmd = 1'b0;
    repeat (3) @(negedge clk50);

    // 5: busy DAC defers writes; two queued steps collapse into one pulse with the latest code.
    p0 = n_pulse;
    exp_q.push_back(456);
    dac.dac_busy = 1'b1;
    target = 12'd456; hven_cmd = 1'b1;
    wait_state("t5_hold", 3, 1'b0, 200);
    check("t5_no_pulse_while_busy", n_pulse - p0, 0);
    dac.dac_busy = 1'b0;
    wait_state("t5_drained", 3, 1'b1, 20);
    repeat (5) @(negedge clk50);
    check("t5_one_pulse", n_pulse - p0, 1);
    check("t5_dac_set", int'(dac.dac_set), 456);

    // 6: DAC stuck busy with a write pending -> sticky fault and SAFE; reset_cmd clears it.
    p0 = n_pulse;
    exp_q.push_back(0);
    dac.dac_busy = 1'b1;
    target = 12'd228;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk50);
      if (fault) begin ok = 1'b1; break; end
    end
    check("t6_fault", int'(ok), 1);
    check("t6_safe", int'(ramp_state), 5);
    check("t6_hven", int'(hven), 0);
    check("t6_no_pulse_while_busy", n_pulse - p0, 0);
    dac.dac_busy = 1'b0;
    hven_cmd = 1'b0;
    repeat (6) @(negedge clk50);
    check("t6_drained", exp_q.size(), 0);
    check("t6_fault_sticky", int'(fault), 1);
    reset_cmd = 1'b1;
    @(negedge clk50);
    reset_cmd = 1'b0;
    check("t6_fault_cleared", int'(fault), 0);
    check("t6_idle", int'(ramp_state), 0);

    // Asynchronous reset mid-ramp.
    expect_ramp(0, 228);
    target = 12'd700; hven_cmd = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk50);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    check("ar_reached_228", int'(ok), 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_state", int'(ramp_state), 0);
    check("ar_hven", int'(hven), 0);
    check("ar_dac_set", int'(dac.dac_set), 0);
    check("ar_pulse", int'(dac.dac_pulse), 0);
    exp_q.delete();
    @(negedge clk50);
    hven_cmd = 1'b0; target = '0;
    rst_n = 1'b1;
    @(negedge clk50);

    // target 0: SETTLE, UP, HOLD without any write.
    p0 = n_pulse;
    hven_cmd = 1'b1;
    wait_state("z_hold", 3, 1'b0, 100);
    check("z_at_target", int'(at_target), 1);
    check("z_no_pulse", n_pulse - p0, 0);

    // Full-scale target: saturates at 4095 without wrapping.
    expect_ramp(0, 4095);
    target = 12'd4095;
    wait_state("max_hold", 3, 1'b1, 600);
    check("max_dac_set", int'(dac.dac_set), 4095);
    check("max_at_target", int'(at_target), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
